// File: rtl/encoder_pkg.sv
// Shared widths, FSM encoding and small helpers for the 8-way round-robin arbiter.
// Both the arbiter and its priority encoder import this package.
package encoder_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef logic [N_REQ-1:0]  req_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [HOLD_W-1:0] hold_t;

    // Bit s of v lands on bit 0, so the search can always start at the bottom.
    function automatic req_t rotate_right(input req_t v, input idx_t s);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> s;
        return dbl[N_REQ-1:0];
    endfunction

    function automatic req_t idx_to_onehot(input idx_t i);
        req_t r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder_8x3.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins.
// valid is low and idx is zero when no input bit is set.
module priority_encoder_8x3
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Walk downward so the last assignment comes from the lowest set bit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a bounded hold time per grant.
// A grant is released by done, by the holder dropping its request, or by hold expiry.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant held; arbitrate over req starting at ptr
// ST_GRANT | grant held by gnt_idx; hold counter runs until a release cause
module rr_arbiter_8
    import encoder_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam hold_t HOLD_LAST = hold_t'(HOLD_MAX - 1);
    localparam hold_t HOLD_SAT  = '1;

    arb_state_e state_q, state_d;
    idx_t       ptr_q, ptr_d;
    hold_t      hold_q, hold_d;
    idx_t       gnt_idx_q, gnt_idx_d;
    req_t       gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    req_t       req_rot;
    idx_t       enc_idx;
    logic       enc_valid;
    idx_t       sel_idx;
    logic       cur_req;
    logic       hold_expired;
    logic       grant_exit;

    assign req_rot = rotate_right(req, ptr_q);

    priority_encoder_8x3 u_prio_enc (
        .in_vec (req_rot),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    // Undo the rotation; the 3-bit add wraps naturally.
    assign sel_idx      = enc_idx + ptr_q;
    assign cur_req      = req[gnt_idx_q];
    assign hold_expired = (hold_q == HOLD_LAST);
    assign grant_exit   = (state_q == ST_GRANT) && (done || !cur_req || hold_expired);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_exit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    gnt_idx_d   = sel_idx;
                    gnt_d       = idx_to_onehot(sel_idx);
                    gnt_valid_d = 1'b1;
                    hold_d      = '0;
                end
            end
            ST_GRANT: begin
                if (grant_exit) begin
                    ptr_d       = gnt_idx_q + 3'd1;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    // done wins over expiry; a dropped request is a plain release.
                    timeout_d   = hold_expired && !done && cur_req;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + hold_t'(1);
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: a short-hold instance for most scenarios
// and a default-parameter instance for the long hold limit.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;

    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    logic [7:0] gnt15;
    logic [2:0] gnt_idx15;
    logic       gnt_valid15;
    logic       timeout15;

    int checks = 0;
    int errors = 0;

    int         exp_q[$];
    bit         sb_en = 1'b1;
    logic       prev_v = 1'b0;
    int         sb_e;
    logic [7:0] sb_oh;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_arbiter_8 dut15 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt15),
        .gnt_idx   (gnt_idx15),
        .gnt_valid (gnt_valid15),
        .timeout   (timeout15)
    );

    // Scoreboard: every new grant on the short-hold instance is matched against the queue.
    always @(negedge clk) begin
        if (sb_en && gnt_valid === 1'b1 && prev_v !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_grant got idx=%0d expected no grant", gnt_idx);
            end else begin
                sb_e  = exp_q.pop_front();
                sb_oh = 8'b1 << sb_e;
                if (gnt_idx !== 3'(sb_e) || gnt !== sb_oh) begin
                    errors++;
                    $display("FAIL sb_grant got idx=%0d gnt=%b expected idx=%0d gnt=%b",
                             gnt_idx, gnt, sb_e, sb_oh);
                end
            end
        end
        prev_v = gnt_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b idx=%0d v=%b to=%b expected all zero",
                     gnt, gnt_idx, gnt_valid, timeout);
        end
        checks++;
        if (gnt15 !== 8'h00 || gnt_valid15 !== 1'b0 || timeout15 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs15 got gnt=%b v=%b to=%b expected all zero",
                     gnt15, gnt_valid15, timeout15);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 8'h01;
        exp_q.push_back(0);
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got gnt=%b idx=%0d v=%b expected gnt=00000001 idx=0 v=1",
                     gnt, gnt_idx, gnt_valid);
        end
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt !== 8'h00) begin
            errors++;
            $display("FAIL single_release got v=%b to=%b gnt=%b expected v=0 to=0 gnt=0",
                     gnt_valid, timeout, gnt);
        end
        exp_q.push_back(0);
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL single_regrant got v=%b idx=%0d expected v=1 idx=0", gnt_valid, gnt_idx);
        end
        // Release with all requesters waiting: the search must start at 1.
        done = 1'b1;
        req  = 8'hFF;
        tick();
        done = 1'b0;
        exp_q.push_back(1);
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd1) begin
            errors++;
            $display("FAIL single_ptr got v=%b idx=%0d expected v=1 idx=1", gnt_valid, gnt_idx);
        end
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_done_idle();
        do_reset();
        req  = 8'h00;
        done = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_idle got v=%b to=%b expected v=0 to=0", gnt_valid, timeout);
        end
        done = 1'b0;
        req  = 8'h02;
        exp_q.push_back(1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    task automatic test_two_way();
        int e;
        do_reset();
        req = 8'h81;
        for (int i = 0; i < 4; i++) begin
            e = (i % 2 == 0) ? 0 : 7;
            exp_q.push_back(e);
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(e)) begin
                errors++;
                $display("FAIL two_way_grant[%0d] got v=%b idx=%0d expected v=1 idx=%0d",
                         i, gnt_valid, gnt_idx, e);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL two_way_gap[%0d] got v=%b expected v=0", i, gnt_valid);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_all_wrap();
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(i % 8);
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(i % 8)) begin
                errors++;
                $display("FAIL all_wrap[%0d] got v=%b idx=%0d expected v=1 idx=%0d",
                         i, gnt_valid, gnt_idx, i % 8);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req = 8'h04;
        exp_q.push_back(2);
        tick();
        cnt = 0;
        while (gnt_valid === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL timeout_hold_len got %0d cycles expected 4", cnt);
        end
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse got to=%b expected 1", timeout);
        end
        exp_q.push_back(2);
        tick();
        checks++;
        if (timeout !== 1'b0 || gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
            errors++;
            $display("FAIL timeout_regrant got to=%b v=%b idx=%0d expected to=0 v=1 idx=2",
                     timeout, gnt_valid, gnt_idx);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    task automatic test_drop_and_tie();
        do_reset();
        req = 8'h60;
        exp_q.push_back(5);
        tick();
        tick();
        req = 8'h41;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_release got v=%b to=%b expected v=0 to=0", gnt_valid, timeout);
        end
        exp_q.push_back(6);
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin
            errors++;
            $display("FAIL drop_ptr got v=%b idx=%0d expected v=1 idx=6", gnt_valid, gnt_idx);
        end
        // done lands on the expiry edge.
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_expiry_tie got v=%b to=%b expected v=0 to=0", gnt_valid, timeout);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h08;
        exp_q.push_back(3);
        tick();
        req = 8'h0F;
        tick();
        checks++;
        if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL grant_stable got gnt=%b idx=%0d v=%b expected gnt=00001000 idx=3 v=1",
                     gnt, gnt_idx, gnt_valid);
        end
        rst = 1'b1;
        req = 8'h09;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got gnt=%b idx=%0d v=%b to=%b expected all zero",
                     gnt, gnt_idx, gnt_valid, timeout);
        end
        rst = 1'b0;
        exp_q.push_back(0);
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_first got v=%b idx=%0d expected v=1 idx=0", gnt_valid, gnt_idx);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();
    endtask

    task automatic test_hold_default();
        int cnt;
        sb_en = 1'b0;
        do_reset();
        req = 8'h04;
        tick();
        cnt = 0;
        while (gnt_valid15 === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 15 || timeout15 !== 1'b1) begin
            errors++;
            $display("FAIL hold_default got %0d cycles to=%b expected 15 cycles to=1", cnt, timeout15);
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_done_idle();
        test_two_way();
        test_all_wrap();
        test_timeout();
        test_drop_and_tie();
        test_reset_mid();
        test_hold_default();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending grants expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
